// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter
//   Modulo-MOD up/down counter over 0..MOD-1 with synchronous clear,
//   parallel load, count enable and a combinational cascade carry.
//   Optional feature macro: MODCNT_PRESCALE_EN (adds a PRESCALE-cycle
//   prescaler so q steps once every PRESCALE enabled cycles).
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous active-high reset
//   en        in   1      count enable
//   up_dn     in   1      1 = count up, 0 = count down
//   clr       in   1      synchronous clear to 0
//   load      in   1      synchronous parallel load
//   load_val  in   WIDTH  value for load
//   q         out  WIDTH  registered count
//   carry_out out  1      combinational; the next edge wraps (cascade enable)
//   wrap      out  1      registered pulse; a wrap occurred on the previous edge
//   load_err  out  1      registered pulse; previous load_val was >= MOD
module mod_n_updown_counter #(
    parameter int unsigned MOD      = 10,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             carry_out,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

    // Elaboration-time parameter sanity checks
    if ((64'd1 << WIDTH) < 64'(MOD)) begin : g_width_chk
        $error("mod_n_updown_counter: 2**WIDTH must be >= MOD");
    end
    if (MOD < 2) begin : g_mod_chk
        $error("mod_n_updown_counter: MOD must be >= 2");
    end
    if (PRESCALE < 1) begin : g_prescale_chk
        $error("mod_n_updown_counter: PRESCALE must be >= 1");
    end

    logic tick;
    logic at_top;
    logic at_zero;
    logic load_ok;

`ifdef MODCNT_PRESCALE_EN
    localparam int unsigned      PS_W    = $clog2(PRESCALE) + 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescaler;

    // Counts enabled cycles; clear and load restart the window
    always_ff @(posedge clk) begin
        if (rst || clr || load) begin
            prescaler <= '0;
        end else if (en) begin
            prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + PS_W'(1);
        end
    end

    assign tick = en & (prescaler == PS_LAST);
`else
    assign tick = 1'b1;
`endif

    assign at_top  = (q == MAX_VAL);
    assign at_zero = (q == '0);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // Not masked by clr/load; those only suppress the wrap pulse
    assign carry_out = en & tick & ((up_dn & at_top) | (~up_dn & at_zero));

    // Count register and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                q <= '0;
            end else if (load) begin
                if (load_ok) begin
                    q <= load_val;
                end else begin
                    q        <= '0;
                    load_err <= 1'b1;
                end
            end else if (en && tick) begin
                if (carry_out) begin
                    q    <= up_dn ? '0 : MAX_VAL;
                    wrap <= 1'b1;
                end else begin
                    q <= up_dn ? q + WIDTH'(1) : q - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed bench for mod_n_updown_counter (MOD=10, WIDTH=4, PRESCALE=4).
// A second instance (tens) is cascaded from the first via carry_out -> en.
module tb_mod_n_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] q;
    logic       carry_out;
    logic       wrap;
    logic       load_err;

    logic       tens_up = 1'b1;
    logic       tens_clr = 1'b0;
    logic       tens_load = 1'b0;
    logic [3:0] tens_load_val = 4'd0;
    logic [3:0] tens_q;
    logic       tens_carry;
    logic       tens_wrap;
    logic       tens_load_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_n_updown_counter #(.MOD(10), .WIDTH(4), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .q(q), .carry_out(carry_out),
        .wrap(wrap), .load_err(load_err)
    );

    mod_n_updown_counter #(.MOD(10), .WIDTH(4), .PRESCALE(4)) tens (
        .clk(clk), .rst(rst), .en(carry_out), .up_dn(tens_up), .clr(tens_clr),
        .load(tens_load), .load_val(tens_load_val), .q(tens_q),
        .carry_out(tens_carry), .wrap(tens_wrap), .load_err(tens_load_err)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

`ifndef MODCNT_PRESCALE_EN
    int exp_up_q[12]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_up_w[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_up_c[12]   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int exp_dn_q[5]    = '{2, 1, 0, 9, 8};
    int exp_dn_w[5]    = '{0, 0, 0, 1, 0};
    int exp_dn_c[5]    = '{0, 0, 0, 1, 0};
`endif

    initial begin
        // Reset for two cycles
        rst = 1'b1;
        step();
        step();
        check("rst_q", q, 0);
        check("rst_wrap", wrap, 0);
        check("rst_load_err", load_err, 0);
        check("rst_carry", carry_out, 0);
        rst = 1'b0;

`ifndef MODCNT_PRESCALE_EN
        // Count up through the wrap
        en = 1'b1;
        up_dn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("up_carry", carry_out, exp_up_c[i]);
            step();
            check("up_q", q, exp_up_q[i]);
            check("up_wrap", wrap, exp_up_w[i]);
        end

        // Load 3 then count down through 0 -> 9
        en = 1'b0;
        load = 1'b1;
        load_val = 4'd3;
        step();
        check("load3_q", q, 3);
        check("load3_err", load_err, 0);
        load = 1'b0;
        en = 1'b1;
        up_dn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("dn_carry", carry_out, exp_dn_c[i]);
            step();
            check("dn_q", q, exp_dn_q[i]);
            check("dn_wrap", wrap, exp_dn_w[i]);
        end

        // Out-of-range load, then max legal load
        en = 1'b0;
        load = 1'b1;
        load_val = 4'd12;
        step();
        check("load12_q", q, 0);
        check("load12_err", load_err, 1);
        load_val = 4'd9;
        step();
        check("load9_q", q, 9);
        check("load9_err", load_err, 0);
        load = 1'b0;
        step();
        check("hold_q", q, 9);
        check("hold_err", load_err, 0);

        // clr coincident with carry: carry visible, no wrap pulse
        en = 1'b1;
        up_dn = 1'b1;
        clr = 1'b1;
        #1;
        check("clr_carry", carry_out, 1);
        step();
        check("clr_q", q, 0);
        check("clr_wrap", wrap, 0);
        clr = 1'b0;

        // load coincident with carry: load wins
        en = 1'b0;
        load = 1'b1;
        load_val = 4'd9;
        step();
        en = 1'b1;
        load_val = 4'd4;
        #1;
        check("ldc_carry", carry_out, 1);
        step();
        check("ldc_q", q, 4);
        check("ldc_wrap", wrap, 0);
        load = 1'b0;
        step();
        check("to5_q", q, 5);

        // Reset mid-count overrides load/en
        rst = 1'b1;
        load = 1'b1;
        load_val = 4'd7;
        step();
        check("midrst_q", q, 0);
        check("midrst_wrap", wrap, 0);
        load = 1'b0;

        // Cascade: units -> tens for 100 cycles
        rst = 1'b1;
        step();
        rst = 1'b0;
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 100) begin
                #1;
                check("tens_carry99", tens_carry, 1);
            end
            step();
            check("units_q", q, k % 10);
            check("tens_q", tens_q, (k / 10) % 10);
        end
        check("tens_wrap100", tens_wrap, 1);
        check("tens_load_err", tens_load_err, 0);
        en = 1'b0;
        step();
        check("tens_wrap_end", tens_wrap, 0);
`else
        // Prescaled: one step per 4 enabled cycles
        en = 1'b1;
        up_dn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check("ps_q", q, k / 4);
        end
        // Two enabled cycles, two idle, then two more complete the window
        step();
        step();
        check("ps_mid_q", q, 4);
        en = 1'b0;
        step();
        step();
        check("ps_idle_q", q, 4);
        en = 1'b1;
        step();
        check("ps_late_q", q, 4);
        step();
        check("ps_step_q", q, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
